alu_32bit_behavioral: RTL and testbench

ALU_32BIT_BEHAVIORAL -- requirements
Module: alu_32bit_behavioral

---
 rtl/alu_32bit_behavioral.sv | 132 +++++++++++++
 tb/tb_alu_32bit_behavioral.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_32bit_behavioral.sv
// -----------------------------------------------------------------------------
// alu_32bit_behavioral
//
// Purpose:
//   32-bit ALU. Arithmetic, logic and single-bit shift operations. The result
//   is available combinationally on F/COUT and as a registered copy on
//   F_Q/COUT_Q, which has one cycle of latency.
//
// Optional feature:
//   Define ALU_FLAGS_EN to add the ZERO/OVF status flags and their registered
//   copies ZERO_Q/OVF_Q. When the macro is undefined, those ports and their
//   logic are absent.
//
// Ports:
//   CLK     in   1       clock; the registered outputs sample on its rising edge
//   RST_N   in   1       asynchronous active-low reset, clears registered outputs
//   A, B    in   DATA_W  operands
//   CIN     in   1       arithmetic carry-in
//   DL      in   1       serial bit shifted into the LSB on shift-left
//   DR      in   1       serial bit shifted into the MSB on shift-right
//   S       in   4       S[3:2] selects the class (arith/logic/shr/shl), S[1:0] the sub-op
//   F       out  DATA_W  combinational result
//   COUT    out  1       combinational carry-out (arithmetic class only)
//   F_Q     out  DATA_W  registered F
//   COUT_Q  out  1       registered COUT
//   ZERO    out  1       F == 0                          (ALU_FLAGS_EN only)
//   OVF     out  1       signed overflow, arith class    (ALU_FLAGS_EN only)
//   ZERO_Q  out  1       registered ZERO                 (ALU_FLAGS_EN only)
//   OVF_Q   out  1       registered OVF                  (ALU_FLAGS_EN only)
// -----------------------------------------------------------------------------
module alu_32bit_behavioral #(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              CIN,
  input  logic              DL,
  input  logic              DR,
  input  logic [3:0]        S,
  output logic [DATA_W-1:0] F,
  output logic              COUT,
  output logic [DATA_W-1:0] F_Q,
`ifdef ALU_FLAGS_EN
  output logic              COUT_Q,
  output logic              ZERO,
  output logic              OVF,
  output logic              ZERO_Q,
  output logic              OVF_Q
`else
  output logic              COUT_Q
`endif
);

  localparam logic [1:0] CLS_ARITH = 2'b00;
  localparam logic [1:0] CLS_LOGIC = 2'b01;
  localparam logic [1:0] CLS_SHR   = 2'b10;
  localparam logic [1:0] CLS_SHL   = 2'b11;

  // A + Y + carry-in, computed one bit wider so that the top bit is the carry out.
  function automatic logic [DATA_W:0] add_c(input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] y,
                                            input logic              c);
    return {1'b0, a} + {1'b0, y} + {{DATA_W{1'b0}}, c};
  endfunction

  logic [DATA_W-1:0] y;
  logic [DATA_W:0]   sum;

  // Second adder operand. Every sub-op maps to a fixed Y, so subtract,
  // increment, decrement and transfer all share a single adder.
  always_comb begin
    y = '0;
    case (S[1:0])
      2'b00:   y = '0;
      2'b01:   y = B;
      2'b10:   y = ~B;
      default: y = '1;
    endcase
  end

  assign sum = add_c(A, y, CIN);

  always_comb begin
    F    = '0;
    COUT = 1'b0;
    case (S[3:2])
      CLS_ARITH: begin
        F    = sum[DATA_W-1:0];
        COUT = sum[DATA_W];
      end
      CLS_LOGIC: begin
        case (S[1:0])
          2'b00:   F = A & B;
          2'b01:   F = A | B;
          2'b10:   F = A ^ B;
          default: F = ~A;
        endcase
      end
      CLS_SHR: F = {DR, A[DATA_W-1:1]};
      default: F = {A[DATA_W-2:0], DL};
    endcase
  end

`ifdef ALU_FLAGS_EN
  assign ZERO = (F == '0);
  // Overflow occurs when the operands have the same sign and the result sign differs.
  assign OVF  = (S[3:2] == CLS_ARITH) && (A[DATA_W-1] == y[DATA_W-1]) &&
                (F[DATA_W-1] != A[DATA_W-1]);
`endif

  // Output register stage: a registered copy of the combinational result.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      F_Q    <= '0;
      COUT_Q <= 1'b0;
`ifdef ALU_FLAGS_EN
      ZERO_Q <= 1'b0;
      OVF_Q  <= 1'b0;
`endif
    end else begin
      F_Q    <= F;
      COUT_Q <= COUT;
`ifdef ALU_FLAGS_EN
      ZERO_Q <= ZERO;
      OVF_Q  <= OVF;
`endif
    end
  end

endmodule

// File: tb/tb_alu_32bit_behavioral.sv
// -----------------------------------------------------------------------------
// tb_alu_32bit_behavioral
//
// Purpose:
//   Self-checking bench for alu_32bit_behavioral. It applies a table of
//   directed vectors, hand-written reset sequences and random vectors. The
//   random vectors are compared against a reference model written in plain
//   arithmetic.
// -----------------------------------------------------------------------------
module tb_alu_32bit_behavioral;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] A, B;
  logic        CIN, DL, DR;
  logic [3:0]  S;
  logic [31:0] F, F_Q;
  logic        COUT, COUT_Q;
`ifdef ALU_FLAGS_EN
  logic        ZERO, OVF, ZERO_Q, OVF_Q;
`endif

  int checks   = 0;
  int failures = 0;

  alu_32bit_behavioral dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .A      (A),
    .B      (B),
    .CIN    (CIN),
    .DL     (DL),
    .DR     (DR),
    .S      (S),
    .F      (F),
    .COUT   (COUT),
    .F_Q    (F_Q),
`ifdef ALU_FLAGS_EN
    .COUT_Q (COUT_Q),
    .ZERO   (ZERO),
    .OVF    (OVF),
    .ZERO_Q (ZERO_Q),
    .OVF_Q  (OVF_Q)
`else
    .COUT_Q (COUT_Q)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        dl;
    logic        dr;
    logic [3:0]  s;
    logic [31:0] f;
    logic        cout;
    logic        zero;
    logic        ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic cin, logic dl,
                              logic dr, logic [3:0] s, logic [31:0] f, logic cout,
                              logic zero, logic ovf);
    vec_t v;
    v.a = a; v.b = b; v.cin = cin; v.dl = dl; v.dr = dr; v.s = s;
    v.f = f; v.cout = cout; v.zero = zero; v.ovf = ovf;
    return v;
  endfunction

  // Reference model: derives the expected results directly from the operation definitions.
  function automatic vec_t model(vec_t v);
    vec_t   r = v;
    longint wide;
    logic [31:0] y;
    y = 32'h0;
    r.cout = 1'b0;
    r.ovf  = 1'b0;
    unique case (v.s)
      4'h0, 4'h1, 4'h2, 4'h3: begin
        if (v.s == 4'h0) y = 32'h0;
        else if (v.s == 4'h1) y = v.b;
        else if (v.s == 4'h2) y = ~v.b;
        else y = 32'hFFFF_FFFF;
        wide   = longint'(v.a) + longint'(y) + longint'(v.cin);
        r.f    = wide[31:0];
        r.cout = (wide >= 64'sd4294967296);
        r.ovf  = ($signed(v.a) >= 0) == ($signed(y) >= 0) &&
                 (($signed(r.f) >= 0) != ($signed(v.a) >= 0));
      end
      4'h4: r.f = v.a & v.b;
      4'h5: r.f = v.a | v.b;
      4'h6: r.f = v.a ^ v.b;
      4'h7: r.f = ~v.a;
      4'h8, 4'h9, 4'hA, 4'hB: r.f = (v.a >> 1) | (v.dr ? 32'h8000_0000 : 32'h0);
      default:                r.f = (v.a << 1) | {31'h0, v.dl};
    endcase
    r.zero = (r.f == 32'h0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    A = v.a; B = v.b; CIN = v.cin; DL = v.dl; DR = v.dr; S = v.s;
  endtask

  // Drive on the falling edge, check the combinational outputs, then clock and check the registered outputs.
  task automatic apply(input string tag, input vec_t v);
    @(negedge CLK);
    drive(v);
    #1;
    chk({tag, ".F"}, F, v.f);
    chk({tag, ".COUT"}, {31'h0, COUT}, {31'h0, v.cout});
`ifdef ALU_FLAGS_EN
    chk({tag, ".ZERO"}, {31'h0, ZERO}, {31'h0, v.zero});
    chk({tag, ".OVF"}, {31'h0, OVF}, {31'h0, v.ovf});
`endif
    @(posedge CLK);
    #1;
    chk({tag, ".F_Q"}, F_Q, v.f);
    chk({tag, ".COUT_Q"}, {31'h0, COUT_Q}, {31'h0, v.cout});
`ifdef ALU_FLAGS_EN
    chk({tag, ".ZERO_Q"}, {31'h0, ZERO_Q}, {31'h0, v.zero});
    chk({tag, ".OVF_Q"}, {31'h0, OVF_Q}, {31'h0, v.ovf});
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v, e;
    RST_N = 1'b0;
    A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; CIN = 1'b0; DL = 1'b0; DR = 1'b0; S = 4'h1;

    //  a             b             cin dl  dr  s     f             cout zero ovf
    tbl.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 4'h1, 32'hFFFF_FFFE, 1, 0, 0));
    tbl.push_back(mk(32'h0000_0003, 32'h0000_0004, 1, 0, 0, 4'h2, 32'hFFFF_FFFF, 0, 0, 0));
    tbl.push_back(mk(32'h0000_0004, 32'h0000_0003, 1, 0, 0, 4'h2, 32'h0000_0001, 1, 0, 0));
    tbl.push_back(mk(32'h0000_0000, 32'h1234_0000, 0, 0, 0, 4'h3, 32'hFFFF_FFFF, 0, 0, 0));
    tbl.push_back(mk(32'h0000_0001, 32'h0000_0000, 0, 0, 0, 4'h3, 32'h0000_0000, 1, 1, 0));
    tbl.push_back(mk(32'hAAAA_AAAA, 32'h5555_5555, 0, 0, 0, 4'h6, 32'hFFFF_FFFF, 0, 0, 0));
    tbl.push_back(mk(32'h0000_0000, 32'hDEAD_BEEF, 1, 1, 1, 4'h7, 32'hFFFF_FFFF, 0, 0, 0));
    tbl.push_back(mk(32'h1234_5678, 32'h0000_0000, 0, 0, 1, 4'h8, 32'h891A_2B3C, 0, 0, 0));
    tbl.push_back(mk(32'h1234_5678, 32'h0000_0000, 0, 1, 0, 4'hC, 32'h2468_ACF1, 0, 0, 0));
    tbl.push_back(mk(32'hFFFF_FFFF, 32'h0000_0000, 1, 0, 0, 4'h0, 32'h0000_0000, 1, 1, 0));
    tbl.push_back(mk(32'h0000_0005, 32'h0000_0000, 1, 0, 0, 4'h3, 32'h0000_0005, 1, 0, 0));
    tbl.push_back(mk(32'hF0F0_F0F0, 32'hFF00_FF00, 1, 1, 1, 4'h4, 32'hF000_F000, 0, 0, 0));
    tbl.push_back(mk(32'hF0F0_0000, 32'h0000_0F0F, 1, 0, 0, 4'h5, 32'hF0F0_0F0F, 0, 0, 0));
    tbl.push_back(mk(32'h0000_0001, 32'hFFFF_FFFF, 1, 1, 0, 4'hB, 32'h0000_0000, 0, 1, 0));
    tbl.push_back(mk(32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 1, 4'hF, 32'h0000_0000, 0, 1, 0));
    tbl.push_back(mk(32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 0, 4'h1, 32'h8000_0000, 0, 0, 1));

    // Registered outputs are cleared while reset is held, even across clock edges.
    repeat (2) @(posedge CLK);
    #1;
    chk("reset.F_Q", F_Q, 32'h0);
    chk("reset.COUT_Q", {31'h0, COUT_Q}, 32'h0);
    chk("reset.F_comb", F, 32'hFFFF_FFFE);
    @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply($sformatf("vec%0d", i), tbl[i]);

    // Reset asserted between edges clears the registers at once but leaves F/COUT alone.
    apply("pre_rst", tbl[0]);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk("midrst.F_Q", F_Q, 32'h0);
    chk("midrst.COUT_Q", {31'h0, COUT_Q}, 32'h0);
    chk("midrst.F", F, 32'hFFFF_FFFE);
    chk("midrst.COUT", {31'h0, COUT}, 32'h1);
    @(posedge CLK);
    #1;
    chk("midrst_hold.F_Q", F_Q, 32'h0);
    // The first edge after release captures the current result.
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    chk("post_rst.F_Q", F_Q, 32'hFFFF_FFFE);
    chk("post_rst.COUT_Q", {31'h0, COUT_Q}, 32'h1);

    // Random vectors checked against the reference model.
    for (int i = 0; i < 300; i++) begin
      v.a   = $urandom;
      v.b   = $urandom;
      v.cin = 1'($urandom_range(0, 1));
      v.dl  = 1'($urandom_range(0, 1));
      v.dr  = 1'($urandom_range(0, 1));
      v.s   = 4'($urandom_range(0, 15));
      if (i % 10 == 0) v.a = (i % 20 == 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
      e = model(v);
      apply($sformatf("rnd%0d_s%0h", i, v.s), e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
